// File: rtl/out_channel_reader.sv
`default_nettype none
// ============================================================================
//  Module      : out_channel_reader
//  Description : Receiving end of the program's out channel. Emitted words are
//                captured into a circular buffer of NOut entries and drained
//                in order over a valid/ready stream. Tracks stored and dropped
//                words, late writes, and completion of the program plus drain.
//  Ports       : clock/reset          - clock, synchronous active-high reset
//                out_write/out_data   - word emitted by the program
//                program_finished     - level, program reached its halt state
//                read_valid/read_data/read_ready - oldest-word output stream
//                count                - words currently buffered
//                words_accepted       - saturating count of stored words
//                overflow/late_write  - sticky error flags
//                drained              - finished and every word read
//  Revision    : 1.0 - initial release
// ============================================================================
module out_channel_reader #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 100,
    parameter int CountWidth         = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          out_write,
    input  logic [MemoryElementWidth-1:0] out_data,
    input  logic                          program_finished,
    output logic                          read_valid,
    output logic [MemoryElementWidth-1:0] read_data,
    input  logic                          read_ready,
    output logic [$clog2(NOut+1)-1:0]     count,
    output logic [CountWidth-1:0]         words_accepted,
    output logic                          overflow,
    output logic                          late_write,
    output logic                          drained
);

    localparam int PTR_W = (NOut > 1) ? $clog2(NOut) : 1;
    localparam int CNT_W = $clog2(NOut + 1);
    localparam logic [PTR_W-1:0]      C_PTR_LAST = PTR_W'(NOut - 1);
    localparam logic [CNT_W-1:0]      C_CNT_FULL = CNT_W'(NOut);
    localparam logic [CountWidth-1:0] C_ACC_MAX  = {CountWidth{1'b1}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Buffer storage: deliberately not reset.
    logic [MemoryElementWidth-1:0] mem_q [NOut];

    state_e                        state_q,          state_d;
    logic [PTR_W-1:0]              wr_ptr_q,         wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q,         rd_ptr_d;
    logic [CNT_W-1:0]              count_q,          count_d;
    logic [CountWidth-1:0]         words_accepted_q, words_accepted_d;
    logic                          overflow_q,       overflow_d;
    logic                          late_write_q,     late_write_d;
    logic                          drained_q,        drained_d;
    logic                          read_valid_q,     read_valid_d;
    logic [MemoryElementWidth-1:0] read_data_q,      read_data_d;

    logic                          w_rd_fire;
    logic                          w_collecting;
    logic                          w_wr_fire;
    logic                          w_drop;
    logic                          w_late;
    logic [MemoryElementWidth-1:0] w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_rd_fire    = read_valid_q & read_ready;
        // A write in the cycle program_finished first rises is already late.
        w_collecting = (state_q == ST_COLLECT) & ~program_finished;
        // A full buffer still accepts a word when a read frees a slot this cycle.
        w_wr_fire    = out_write & w_collecting & ((count_q != C_CNT_FULL) | w_rd_fire);
        w_drop       = out_write & w_collecting & ~w_wr_fire;
        w_late       = out_write & ~w_collecting;

        wr_ptr_d = w_wr_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_rd_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (w_wr_fire && !w_rd_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_rd_fire && !w_wr_fire) begin
            count_d = count_q - CNT_W'(1);
        end

        words_accepted_d = words_accepted_q;
        if (w_wr_fire && (words_accepted_q != C_ACC_MAX)) begin
            words_accepted_d = words_accepted_q + CountWidth'(1);
        end

        overflow_d   = overflow_q   | w_drop;
        late_write_d = late_write_q | w_late;

        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (program_finished) state_d = ST_DRAIN;
            ST_DRAIN:   if (count_d == '0)    state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_COLLECT;
        endcase
        drained_d = (state_d == ST_DONE);

        // The output register is loaded with the next head word. When the head
        // is the word being written this edge it is not in memory yet, so it is
        // taken from the input directly.
        if (w_wr_fire && (rd_ptr_d == wr_ptr_q)) begin
            w_head = out_data;
        end else begin
            w_head = mem_q[rd_ptr_d];
        end
        read_valid_d = (count_d != '0);
        read_data_d  = read_valid_d ? w_head : '0;
    end

    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            mem_q[wr_ptr_q] <= out_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_COLLECT;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            words_accepted_q <= '0;
            overflow_q       <= 1'b0;
            late_write_q     <= 1'b0;
            drained_q        <= 1'b0;
            read_valid_q     <= 1'b0;
            read_data_q      <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            words_accepted_q <= words_accepted_d;
            overflow_q       <= overflow_d;
            late_write_q     <= late_write_d;
            drained_q        <= drained_d;
            read_valid_q     <= read_valid_d;
            read_data_q      <= read_data_d;
        end
    end

    assign read_valid     = read_valid_q;
    assign read_data      = read_data_q;
    assign count          = count_q;
    assign words_accepted = words_accepted_q;
    assign overflow       = overflow_q;
    assign late_write     = late_write_q;
    assign drained        = drained_q;

endmodule
`default_nettype wire

// File: tb/tb_out_channel_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_channel_reader
//  Description : Self-checking bench for out_channel_reader (depth 4, small
//                accepted-word counter so saturation is reachable). Directed
//                vector table, hand-written finish/reset sequences, and a
//                randomized run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_channel_reader;

    localparam int W      = 12;
    localparam int N      = 4;
    localparam int CW     = 5;
    localparam int ACCMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          out_write;
    logic [W-1:0]  out_data;
    logic          program_finished;
    logic          read_valid;
    logic [W-1:0]  read_data;
    logic          read_ready;
    logic [2:0]    count;
    logic [CW-1:0] words_accepted;
    logic          overflow;
    logic          late_write;
    logic          drained;

    out_channel_reader #(
        .MemoryElementWidth(W),
        .NOut              (N),
        .CountWidth        (CW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .out_write       (out_write),
        .out_data        (out_data),
        .program_finished(program_finished),
        .read_valid      (read_valid),
        .read_data       (read_data),
        .read_ready      (read_ready),
        .count           (count),
        .words_accepted  (words_accepted),
        .overflow        (overflow),
        .late_write      (late_write),
        .drained         (drained)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the buffer as a plain FIFO queue plus flags.
    int m_q[$];
    bit m_fin, m_done, m_ovf, m_late;
    int m_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit w, input int d, input bit pf, input bit rdy);
        bit rd;
        bit fin_before;
        if (r) begin
            m_q.delete();
            m_fin = 0; m_done = 0; m_ovf = 0; m_late = 0; m_acc = 0;
        end else begin
            rd         = (m_q.size() != 0) && rdy;
            fin_before = m_fin;
            if (w) begin
                if (m_fin || pf) m_late = 1;
                else if (m_q.size() < N || rd) begin
                    m_q.push_back(d & ((1 << W) - 1));
                    if (m_acc < ACCMAX) m_acc++;
                end else m_ovf = 1;
            end
            if (rd) void'(m_q.pop_front());
            if (pf) m_fin = 1;
            if (fin_before && m_q.size() == 0) m_done = 1;
        end
    endtask

    task automatic model_check(input string tag);
        int exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : 0;
        chk({tag, " read_valid"},     32'(read_valid),     32'(m_q.size() != 0));
        chk({tag, " read_data"},      32'(read_data),      32'(exp_data));
        chk({tag, " count"},          32'(count),          32'(m_q.size()));
        chk({tag, " words_accepted"}, 32'(words_accepted), 32'(m_acc));
        chk({tag, " overflow"},       32'(overflow),       32'(m_ovf));
        chk({tag, " late_write"},     32'(late_write),     32'(m_late));
        chk({tag, " drained"},        32'(drained),        32'(m_done));
    endtask

    // Apply one cycle of inputs, advance model across the edge, check #1 later.
    task automatic step(input bit r, input bit w, input int d, input bit pf, input bit rdy,
                        input string tag);
        reset            = r;
        out_write        = w;
        out_data         = d[W-1:0];
        program_finished = pf;
        read_ready       = rdy;
        @(posedge clock);
        model_edge(r, w, d, pf, rdy);
        #1;
        model_check(tag);
    endtask

    typedef struct {
        bit r, w;
        int d;
        bit pf, rdy;
        bit ev;
        int ed;
        int ec;
        bit eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit r, input bit w, input int d, input bit pf, input bit rdy,
                                input bit ev, input int ed, input int ec, input bit eovf);
        vec_t v;
        v.r = r; v.w = w; v.d = d; v.pf = pf; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eovf = eovf;
        vecs.push_back(v);
    endfunction

    initial begin
        bit pf_lvl;
        bit r, w, rdy;

        // Buffered words then a paced drain
        add(0,1,10,0,0, 1,10,1,0);
        add(0,1,20,0,0, 1,10,2,0);
        add(0,1,30,0,0, 1,10,3,0);
        add(0,0, 0,0,1, 1,20,2,0);
        add(0,0, 0,0,1, 1,30,1,0);
        add(0,0, 0,0,1, 0, 0,0,0);
        // Overflow on the fifth write into a depth-4 buffer
        add(0,1,1,0,0, 1,1,1,0);
        add(0,1,2,0,0, 1,1,2,0);
        add(0,1,3,0,0, 1,1,3,0);
        add(0,1,4,0,0, 1,1,4,0);
        add(0,1,5,0,0, 1,1,4,1);
        add(0,0,0,0,1, 1,2,3,1);
        add(0,0,0,0,1, 1,3,2,1);
        add(0,0,0,0,1, 1,4,1,1);
        add(0,0,0,0,1, 0,0,0,1);
        add(1,0,0,0,0, 0,0,0,0);
        // Full buffer accepts a write when a read happens the same cycle
        add(0,1,1,0,0, 1,1,1,0);
        add(0,1,2,0,0, 1,1,2,0);
        add(0,1,3,0,0, 1,1,3,0);
        add(0,1,4,0,0, 1,1,4,0);
        add(0,1,9,0,1, 1,2,4,0);
        add(0,0,0,0,1, 1,3,3,0);
        add(0,0,0,0,1, 1,4,2,0);
        add(0,0,0,0,1, 1,9,1,0);
        add(0,0,0,0,1, 0,0,0,0);
        // Streaming through with wrap-around
        for (int k = 0; k < 10; k++) add(0,1,k,0,1, 1,k,1,0);
        add(0,0,0,0,1, 0,0,0,0);

        step(1,0,0,0,0, "reset");
        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vecs[i].r, vecs[i].w, vecs[i].d, vecs[i].pf, vecs[i].rdy, t);
            chk({t, " tbl_valid"},    32'(read_valid), 32'(vecs[i].ev));
            chk({t, " tbl_data"},     32'(read_data),  32'(vecs[i].ed));
            chk({t, " tbl_count"},    32'(count),      32'(vecs[i].ec));
            chk({t, " tbl_overflow"}, 32'(overflow),   32'(vecs[i].eovf));
        end

        // Late write at finish, then drained after the last read
        step(1,0,0,0,0, "fin_rst");
        step(0,1,2,0,0, "fin_w2");
        step(0,1,7,0,0, "fin_w7");
        step(0,1,5,1,0, "fin_w5");
        chk("fin late_write", 32'(late_write), 32'd1);
        chk("fin count",      32'(count),      32'd2);
        step(0,0,0,1,1, "fin_rd1");
        chk("fin rd1 data",    32'(read_data), 32'd7);
        chk("fin rd1 drained", 32'(drained),   32'd0);
        step(0,0,0,1,1, "fin_rd2");
        chk("fin rd2 drained", 32'(drained),    32'd1);
        chk("fin rd2 valid",   32'(read_valid), 32'd0);
        step(0,1,6,1,1, "fin_after");
        chk("fin no5 valid",   32'(read_valid), 32'd0);

        // Reset while draining
        step(1,0,0,0,0, "rs_rst");
        step(0,1,11,0,0, "rs_w1");
        step(0,1,12,0,0, "rs_w2");
        step(0,1,13,0,0, "rs_w3");
        step(0,0,0,1,0,  "rs_fin");
        step(1,0,0,1,0,  "rs_mid");
        chk("rs count",    32'(count),      32'd0);
        chk("rs valid",    32'(read_valid), 32'd0);
        chk("rs drained",  32'(drained),    32'd0);
        chk("rs overflow", 32'(overflow),   32'd0);
        step(0,1,42,0,0, "rs_w42");
        chk("rs new valid", 32'(read_valid), 32'd1);
        chk("rs new data",  32'(read_data),  32'd42);

        // Randomized run against the model
        pf_lvl = 0;
        step(1,0,0,0,0, "rnd_rst");
        for (int c = 0; c < 3000; c++) begin
            r      = ($urandom_range(0, 299) == 0);
            w      = ($urandom_range(0, 99) < 55);
            rdy    = ($urandom_range(0, 99) < 45);
            pf_lvl = r ? 1'b0 : (pf_lvl | ($urandom_range(0, 249) == 0));
            step(r, w, int'($urandom_range(0, 4095)), pf_lvl, rdy, $sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
